wb_gpio_w: RTL and testbench
============================

Name: wb_gpio_w

Overview:
- Wishbone-slave GPIO controller that replaces the write-only pad register on the 0x8000_2000 interconnect slot.
- Drives output pads and output enables, and samples input pads through a 2-flop synchroniser.
- Detects per-pin rising/falling edges and raises a level interrupt into the PIC irq vector.
- Sits directly downstream of the interconnect slave port and upstream of the PIC.

Parameters:
NUM_PINS, 4, number of GPIO pins (1..32)
RESET_OUT, 0, reset value of OUT register (NUM_PINS bits)

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous, active-high reset
s  wb_if.slave  32-bit addr / 32-bit data  Wishbone slave (ADR, DAT_W, DAT_R, SEL, WE, CYC, STB, ACK, ERR)
pad_i  input  NUM_PINS  asynchronous pad inputs
pad_o  output  NUM_PINS  pad output values (= OUT register)
pad_oe  output  NUM_PINS  pad output enables (= OE register)
int_o  output  1  level interrupt to PIC

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - OUT=RESET_OUT; OE=0; IRQ_EN=0; IRQ_EDGE=0; IRQ_STAT=0.
  - Synchroniser and previous-sample flops are cleared.
  - ACK=0, ERR=0 always (ERR is tied low), DAT_R=0, int_o=0.
  - Reset mid-transaction drops ACK in the same cycle and discards the access.
- Register map, decoded on ADR[4:2]; upper address bits are ignored because the interconnect decodes them:
  - 0 OUT (RW)
  - 1 IN (RO, synchronised value)
  - 2 OE (RW)
  - 3 IRQ_EN (RW)
  - 4 IRQ_EDGE (RW; 1=rising, 0=falling per pin)
  - 5 IRQ_STAT (RW1C)
  - 6,7 read 0; writes are ignored.
- All reads zero-extend bits above NUM_PINS. Writes to bits >= NUM_PINS have no effect.
- Handshake:
  - An access is CYC&STB&!ACK. ACK is registered: high for exactly 1 cycle, the cycle after the access is seen, then low for at least 1 cycle. Single-beat only; one access per 2 cycles max.
  - Writes commit on the same edge ACK rises. Byte lanes are honoured: SEL[k] enables bits [8k+7:8k].
  - DAT_R is valid while ACK is high; 0 otherwise.
  - If STB drops before ACK, the access is still completed (no abort).
- Input path: pad_i -> sync1 -> sync2 (IN) -> prev.
  - IN lags pad_i by 2 clocks.
  - Edge detection: rise = IN&~prev, fall = ~IN&prev. Edge seen 3 clocks after the pad change.
- IRQ_STAT[i] sets on the selected edge regardless of IRQ_EN. Enables only gate int_o.
- Status clear:
  - A write of 1 to IRQ_STAT[i] clears it.
  - Same-cycle new edge and W1C on the same bit: set wins (bit stays 1).
- int_o = |(IRQ_STAT & IRQ_EN), registered (1 cycle after the status/enable update).
- Changing IRQ_EDGE does not retroactively set status. Edges are evaluated with the IRQ_EDGE value current in that cycle.
- pad_o/pad_oe are driven directly from the registers (no extra latency after the write edge).

Test Plan:
- Reset then read all 8 offsets -> OUT=RESET_OUT, all others 0; each ACK exactly 1 cycle; ERR never high; int_o=0.
- Write 0x0000_000A to OUT with SEL=4'b0001, then 0xFFFF_FF05 with SEL=4'b0000 -> pad_o=4'hA after the first write; the second write leaves pad_o=4'hA; readback 0xA.
- Drive pad_i=4'b0100 -> IN reads 0x4 starting 2 clocks later. Glitch-free pad change 1 clock before the read still returns the old value.
- IRQ_EDGE=0x1, IRQ_EN=0x1, pulse pad_i[0] 0->1 -> IRQ_STAT=0x1 three clocks after the edge, int_o high one clock later. Falling edge on pad_i[0] produces no new set. W1C 0x1 -> IRQ_STAT=0, int_o drops one cycle later.
- IRQ_EDGE=0x0, IRQ_EN=0, falling edge on pin 2 -> IRQ_STAT=0x4 with int_o=0. Then write IRQ_EN=0x4 -> int_o=1.
- Arrange W1C of bit 1 in the same cycle a new rising edge on pin 1 is detected -> IRQ_STAT[1] stays 1. Assert rst_i during a pending access -> no ACK, OUT returns to RESET_OUT.

Source files
------------

// File: rtl/wb_gpio_w.sv
// Wishbone slave GPIO: output and output-enable registers, synchronised pad inputs,
// and per-pin edge detection feeding a write-one-to-clear status with a level interrupt.
module wb_gpio_w #(
  parameter int unsigned         NUM_PINS  = 4,
  parameter logic [NUM_PINS-1:0] RESET_OUT = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         s_adr,
  input  logic [31:0]         s_dat_w,
  output logic [31:0]         s_dat_r,
  input  logic [3:0]          s_sel,
  input  logic                s_we,
  input  logic                s_cyc,
  input  logic                s_stb,
  output logic                s_ack,
  output logic                s_err,
  input  logic [NUM_PINS-1:0] pad_i,
  output logic [NUM_PINS-1:0] pad_o,
  output logic [NUM_PINS-1:0] pad_oe,
  output logic                int_o
);

  localparam logic [2:0] ADDR_OUT      = 3'd0;
  localparam logic [2:0] ADDR_IN       = 3'd1;
  localparam logic [2:0] ADDR_OE       = 3'd2;
  localparam logic [2:0] ADDR_IRQ_EN   = 3'd3;
  localparam logic [2:0] ADDR_IRQ_EDGE = 3'd4;
  localparam logic [2:0] ADDR_IRQ_STAT = 3'd5;

  logic [NUM_PINS-1:0] out_reg, out_next;
  logic [NUM_PINS-1:0] oe_reg, oe_next;
  logic [NUM_PINS-1:0] irq_en_reg, irq_en_next;
  logic [NUM_PINS-1:0] irq_edge_reg, irq_edge_next;
  logic [NUM_PINS-1:0] irq_stat_reg, irq_stat_next;
  logic [NUM_PINS-1:0] sync1, sync2, prev;
  logic                ack_reg;
  logic [31:0]         dat_r_reg;
  logic                int_reg;

  logic                access;
  logic                wr_en;
  logic [2:0]          reg_sel;
  logic [31:0]         lane_mask;
  logic [NUM_PINS-1:0] wmask;
  logic [NUM_PINS-1:0] wdata;
  logic [NUM_PINS-1:0] w1c;
  logic [NUM_PINS-1:0] rise, fall, edge_hit;
  logic [NUM_PINS-1:0] rd_pins;
  logic [31:0]         rd_word;

  // Upper address bits are decoded by the interconnect; pin-external data lanes are dropped.
  logic unused_bits;
  assign unused_bits = ^{s_adr[31:5], s_adr[1:0], s_dat_w, lane_mask};

  assign access    = s_cyc & s_stb & ~ack_reg;
  assign wr_en     = access & s_we;
  assign reg_sel   = s_adr[4:2];
  assign lane_mask = {{8{s_sel[3]}}, {8{s_sel[2]}}, {8{s_sel[1]}}, {8{s_sel[0]}}};
  assign wmask     = lane_mask[NUM_PINS-1:0];
  assign wdata     = s_dat_w[NUM_PINS-1:0];

  assign rise     = sync2 & ~prev;
  assign fall     = ~sync2 & prev;
  assign edge_hit = (irq_edge_reg & rise) | (~irq_edge_reg & fall);

  function automatic logic [NUM_PINS-1:0] merge(input logic [NUM_PINS-1:0] old_v,
                                                input logic [NUM_PINS-1:0] new_v,
                                                input logic [NUM_PINS-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  always_comb begin
    out_next      = out_reg;
    oe_next       = oe_reg;
    irq_en_next   = irq_en_reg;
    irq_edge_next = irq_edge_reg;
    w1c           = '0;
    if (wr_en) begin
      case (reg_sel)
        ADDR_OUT:      out_next      = merge(out_reg, wdata, wmask);
        ADDR_OE:       oe_next       = merge(oe_reg, wdata, wmask);
        ADDR_IRQ_EN:   irq_en_next   = merge(irq_en_reg, wdata, wmask);
        ADDR_IRQ_EDGE: irq_edge_next = merge(irq_edge_reg, wdata, wmask);
        ADDR_IRQ_STAT: w1c           = wdata & wmask;
        default:       ;
      endcase
    end
    // A new edge in the same cycle as its clear keeps the bit set.
    irq_stat_next = (irq_stat_reg & ~w1c) | edge_hit;
  end

  always_comb begin
    rd_pins = '0;
    case (reg_sel)
      ADDR_OUT:      rd_pins = out_reg;
      ADDR_IN:       rd_pins = sync2;
      ADDR_OE:       rd_pins = oe_reg;
      ADDR_IRQ_EN:   rd_pins = irq_en_reg;
      ADDR_IRQ_EDGE: rd_pins = irq_edge_reg;
      ADDR_IRQ_STAT: rd_pins = irq_stat_reg;
      default:       rd_pins = '0;
    endcase
    rd_word                 = '0;
    rd_word[NUM_PINS-1:0]   = rd_pins;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_reg      <= RESET_OUT;
      oe_reg       <= '0;
      irq_en_reg   <= '0;
      irq_edge_reg <= '0;
      irq_stat_reg <= '0;
      sync1        <= '0;
      sync2        <= '0;
      prev         <= '0;
      ack_reg      <= 1'b0;
      dat_r_reg    <= '0;
      int_reg      <= 1'b0;
    end else begin
      out_reg      <= out_next;
      oe_reg       <= oe_next;
      irq_en_reg   <= irq_en_next;
      irq_edge_reg <= irq_edge_next;
      irq_stat_reg <= irq_stat_next;
      sync1        <= pad_i;
      sync2        <= sync1;
      prev         <= sync2;
      ack_reg      <= access;
      dat_r_reg    <= (access && !s_we) ? rd_word : 32'h0;
      int_reg      <= |(irq_stat_reg & irq_en_reg);
    end
  end

  assign s_ack   = ack_reg;
  assign s_err   = 1'b0;
  assign s_dat_r = dat_r_reg;
  assign pad_o   = out_reg;
  assign pad_oe  = oe_reg;
  assign int_o   = int_reg;

endmodule

// File: tb/tb_wb_gpio_w.sv
// Directed bench for wb_gpio_w: register access, input synchroniser timing,
// edge interrupts, W1C/edge collision and reset during a pending access.
module tb_wb_gpio_w;

  localparam logic [31:0] BASE = 32'h8000_2000;

  logic        clk;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;
  logic [3:0]  pad_in;
  logic [3:0]  pad_out;
  logic [3:0]  pad_en;
  logic        irq;

  int unsigned vectors;
  int unsigned miscompares;
  logic [31:0] rd;

  wb_gpio_w #(
    .NUM_PINS  (4),
    .RESET_OUT (4'h5)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .s_adr   (adr),
    .s_dat_w (dat_w),
    .s_dat_r (dat_r),
    .s_sel   (sel),
    .s_we    (we),
    .s_cyc   (cyc),
    .s_stb   (stb),
    .s_ack   (ack),
    .s_err   (err),
    .pad_i   (pad_in),
    .pad_o   (pad_out),
    .pad_oe  (pad_en),
    .int_o   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    adr = a; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    tick();
    check("rd_ack", 32'(ack), 32'd1);
    check("rd_err", 32'(err), 32'd0);
    d = dat_r;
    cyc = 1'b0; stb = 1'b0;
    tick();
    check("rd_ack_low", 32'(ack), 32'd0);
    check("rd_dat_idle", dat_r, 32'd0);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    adr = a; dat_w = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    tick();
    check("wr_ack", 32'(ack), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    check("wr_ack_low", 32'(ack), 32'd0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; adr = '0; dat_w = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    pad_in = 4'h0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state and all eight offsets.
    check("rst_pad_o", 32'(pad_out), 32'h5);
    check("rst_pad_oe", 32'(pad_en), 32'h0);
    check("rst_int", 32'(irq), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    for (int i = 0; i < 8; i++) begin
      wb_read(BASE + 32'(i * 4), rd);
      check($sformatf("rst_rd_off%0d", i), rd, (i == 0) ? 32'h5 : 32'h0);
    end

    // Byte lanes on OUT.
    wb_write(BASE + 32'h0, 32'h0000_000A, 4'b0001);
    check("out_lane0", 32'(pad_out), 32'hA);
    wb_write(BASE + 32'h0, 32'hFFFF_FF05, 4'b0000);
    check("out_nosel", 32'(pad_out), 32'hA);
    wb_read(BASE + 32'h0, rd);
    check("out_rd", rd, 32'hA);

    // OE zero-extension, high lanes, reserved and read-only offsets.
    wb_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
    check("oe_all", 32'(pad_en), 32'hF);
    wb_read(BASE + 32'h8, rd);
    check("oe_rd_zext", rd, 32'hF);
    wb_write(BASE + 32'h8, 32'h0000_0300, 4'b0010);
    check("oe_hi_lane", 32'(pad_en), 32'hF);
    wb_write(BASE + 32'h18, 32'hFFFF_FFFF, 4'hF);
    wb_read(BASE + 32'h18, rd);
    check("off6_rd", rd, 32'h0);
    wb_write(BASE + 32'h4, 32'hFFFF_FFFF, 4'hF);
    wb_read(BASE + 32'h4, rd);
    check("in_ro", rd, 32'h0);
    check("out_kept", 32'(pad_out), 32'hA);
    wb_write(BASE + 32'h8, 32'h0, 4'hF);
    check("oe_clr", 32'(pad_en), 32'h0);

    // Input synchroniser latency.
    pad_in = 4'b0100;
    tick();
    wb_read(BASE + 32'h4, rd);
    check("in_old", rd, 32'h0);
    wb_read(BASE + 32'h4, rd);
    check("in_new", rd, 32'h4);

    // Rising-edge interrupt on pin 0.
    wb_write(BASE + 32'h10, 32'h1, 4'hF);
    wb_write(BASE + 32'hC, 32'h1, 4'hF);
    pad_in = 4'b0101;
    tick();
    tick();
    check("rise_int_e2", 32'(irq), 32'h0);
    wb_read(BASE + 32'h14, rd);
    check("stat_before_e3", rd, 32'h0);
    check("rise_int_e4", 32'(irq), 32'h1);
    wb_read(BASE + 32'h14, rd);
    check("stat_rise", rd, 32'h1);
    pad_in = 4'b0100;
    repeat (5) tick();
    wb_read(BASE + 32'h14, rd);
    check("stat_no_fall", rd, 32'h1);
    check("int_held", 32'(irq), 32'h1);
    adr = BASE + 32'h14; dat_w = 32'h1; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    tick();
    check("w1c_ack", 32'(ack), 32'h1);
    check("w1c_int_lag", 32'(irq), 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    check("w1c_int_drop", 32'(irq), 32'h0);
    wb_read(BASE + 32'h14, rd);
    check("stat_cleared", rd, 32'h0);

    // Falling edge on pin 2 with interrupts masked.
    wb_write(BASE + 32'h10, 32'h0, 4'hF);
    wb_write(BASE + 32'hC, 32'h0, 4'hF);
    pad_in = 4'b0000;
    repeat (4) tick();
    wb_read(BASE + 32'h14, rd);
    check("stat_fall2", rd, 32'h4);
    check("fall_masked", 32'(irq), 32'h0);
    wb_write(BASE + 32'hC, 32'h4, 4'hF);
    check("en_unmask", 32'(irq), 32'h1);

    // W1C and new rising edge on pin 1 in the same cycle.
    wb_write(BASE + 32'h10, 32'h2, 4'hF);
    wb_write(BASE + 32'h14, 32'h4, 4'hF);
    check("int_after_clr", 32'(irq), 32'h0);
    wb_read(BASE + 32'h14, rd);
    check("stat_zero", rd, 32'h0);
    pad_in = 4'b0010;
    tick();
    tick();
    adr = BASE + 32'h14; dat_w = 32'h2; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    tick();
    check("coll_ack", 32'(ack), 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    wb_read(BASE + 32'h14, rd);
    check("coll_set_wins", rd, 32'h2);
    wb_write(BASE + 32'h14, 32'h2, 4'hF);
    wb_read(BASE + 32'h14, rd);
    check("coll_then_clr", rd, 32'h0);

    // Reset during a pending write.
    wb_write(BASE + 32'h0, 32'hC, 4'hF);
    check("out_c", 32'(pad_out), 32'hC);
    adr = BASE; dat_w = 32'h3; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    rst = 1'b1;
    tick();
    check("rst_mid_ack", 32'(ack), 32'h0);
    check("rst_mid_out", 32'(pad_out), 32'h5);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
    tick();
    check("rst_post_ack", 32'(ack), 32'h0);
    check("rst_post_out", 32'(pad_out), 32'h5);
    wb_read(BASE + 32'h0, rd);
    check("rst_out_rd", rd, 32'h5);
    wb_read(BASE + 32'hC, rd);
    check("rst_en_rd", rd, 32'h0);
    check("rst_int_low", 32'(irq), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
